ram_access_ctrl: RTL and testbench

Initiator-side controller for the 64 x 16 gate-level RAM block. It accepts single-word read/write requests on a valid/ready request channel and drives the RAM's enable, write, read, address and data pins. It samples RAM read data and returns it on a valid/ready response channel. After reset it optionally zero-fills all 64 words, so the processor datapath never reads unknown contents.

---
 rtl/ram_access_ctrl.sv | 96 +++++++++
 tb/tb_ram_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Initiator-side controller for the 64x16 RAM block.
// Single-word requests in, read responses out, optional fill after reset.
module ram_access_ctrl #(
  parameter bit          INIT_EN  = 1'b1,
  parameter logic [15:0] INIT_VAL = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [5:0]  REQ_ADDR,
  input  logic [15:0] REQ_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic        INIT_DONE,
  output logic        MEM_E,
  output logic        MEM_W,
  output logic        MEM_R,
  output logic [5:0]  MEM_ADDR,
  output logic [15:0] MEM_D,
  input  logic [15:0] MEM_Q
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [5:0]  cnt;
  logic [5:0]  addr_q;
  logic [15:0] data_q;
  logic [15:0] rsp_q;
  logic        done_q;

  logic in_init;
  logic in_wr;
  logic in_rd;

  assign in_init = (state == S_INIT);
  assign in_wr   = (state == S_WR);
  assign in_rd   = (state == S_RD);

  always_comb begin
    nxt = state;
    unique case (state)
      S_INIT: if (cnt == 6'd63) nxt = S_IDLE;
      S_IDLE: if (REQ_VALID) nxt = REQ_WR ? S_WR : S_RD;
      S_WR:   nxt = S_IDLE;
      S_RD:   nxt = S_RSP;
      S_RSP:  if (RSP_READY) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= INIT_EN ? S_INIT : S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      rsp_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      if (in_init) begin
        cnt <= cnt + 6'd1;
        if (cnt == 6'd63) done_q <= 1'b1;
      end
      if (state == S_IDLE && REQ_VALID) begin
        addr_q <= REQ_ADDR;
        data_q <= REQ_DATA;
      end
      if (in_rd) rsp_q <= MEM_Q;
    end
  end

  // Gating by RST drops every strobe the instant reset asserts.
  assign REQ_READY = !RST && (state == S_IDLE);
  assign RSP_VALID = !RST && (state == S_RSP);
  assign RSP_DATA  = rsp_q;
  assign INIT_DONE = !RST && (done_q || !INIT_EN);

  assign MEM_E    = !RST && (in_init || in_wr || in_rd);
  assign MEM_W    = !RST && (in_init || in_wr);
  assign MEM_R    = !RST && in_rd;
  assign MEM_ADDR = in_init ? cnt : addr_q;
  assign MEM_D    = RST ? 16'h0000 : (in_init ? INIT_VAL : data_q);

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM plus
// a word-array reference model, randomized traffic.
module tb_ram_access_ctrl;

  localparam logic [15:0] IV = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst0;
  logic        req_valid, req_ready, req_wr;
  logic [5:0]  req_addr;
  logic [15:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        init_done;
  logic        mem_e, mem_w, mem_r;
  logic [5:0]  mem_addr;
  logic [15:0] mem_d, mem_q;

  logic        req_valid0, req_ready0, req_wr0;
  logic [5:0]  req_addr0;
  logic [15:0] req_data0;
  logic        rsp_valid0, rsp_ready0;
  logic [15:0] rsp_data0;
  logic        init_done0;
  logic        mem_e0, mem_w0, mem_r0;
  logic [5:0]  mem_addr0;
  logic [15:0] mem_d0, mem_q0;

  ram_access_ctrl #(.INIT_EN(1'b1), .INIT_VAL(IV)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data), .INIT_DONE(init_done),
    .MEM_E(mem_e), .MEM_W(mem_w), .MEM_R(mem_r),
    .MEM_ADDR(mem_addr), .MEM_D(mem_d), .MEM_Q(mem_q)
  );

  ram_access_ctrl #(.INIT_EN(1'b0), .INIT_VAL(16'hFFFF)) dut0 (
    .CLK(clk), .RST(rst0),
    .REQ_VALID(req_valid0), .REQ_READY(req_ready0),
    .REQ_WR(req_wr0), .REQ_ADDR(req_addr0), .REQ_DATA(req_data0),
    .RSP_VALID(rsp_valid0), .RSP_READY(rsp_ready0),
    .RSP_DATA(rsp_data0), .INIT_DONE(init_done0),
    .MEM_E(mem_e0), .MEM_W(mem_w0), .MEM_R(mem_r0),
    .MEM_ADDR(mem_addr0), .MEM_D(mem_d0), .MEM_Q(mem_q0)
  );

  logic [15:0] ram  [64];
  logic [15:0] ram0 [64];

  always @(posedge clk) if (mem_e && mem_w) ram[mem_addr] <= mem_d;
  always @(posedge clk) if (mem_e0 && mem_w0) ram0[mem_addr0] <= mem_d0;
  assign mem_q  = (mem_e && mem_r) ? ram[mem_addr] : 16'hxxxx;
  assign mem_q0 = (mem_e0 && mem_r0) ? ram0[mem_addr0] : 16'hxxxx;

  logic [15:0] ref_mem [64];
  int nchk = 0;
  int nerr = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("ready_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_rdy", req_ready, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_rspd", rsp_data, 0);
    check("rst_done", init_done, 0);
    check("rst_e", mem_e, 0);
    check("rst_w", mem_w, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_d", mem_d, 0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 64; k++) begin
      check("fill_w", mem_w, 1);
      check("fill_addr", mem_addr, k);
      check("fill_rdy", req_ready, 0);
      tick();
    end
    check("fill_end_rdy", req_ready, 1);
    check("fill_done", init_done, 1);
    for (int k = 0; k < 64; k++) ref_mem[k] = IV;
  endtask

  task automatic do_write(logic [5:0] a, logic [15:0] d);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = a;
    req_data  = d;
    wait_ready();
    tick();
    req_valid = 1'b0;
    check("wr_w", mem_w, 1);
    check("wr_r", mem_r, 0);
    check("wr_addr", mem_addr, a);
    check("wr_d", mem_d, d);
    tick();
    check("wr_pulse", mem_w, 0);
    check("wr_rdy", req_ready, 1);
    ref_mem[a] = d;
  endtask

  task automatic do_read(logic [5:0] a, int hold, bit inj);
    logic [15:0] first;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = a;
    wait_ready();
    tick();
    req_valid = 1'b0;
    check("rd_r", mem_r, 1);
    check("rd_w", mem_w, 0);
    tick();
    check("rsp_valid", rsp_valid, 1);
    check("rd_data", rsp_data, ref_mem[a]);
    first = rsp_data;
    if (inj) begin
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = a;
      req_data  = ~ref_mem[a];
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, first);
      check("bp_rdy", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_done", rsp_valid, 0);
    check("rsp_idle", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    rst0 = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = 0; req_data = 0;
    rsp_ready = 0;
    req_valid0 = 0; req_wr0 = 0; req_addr0 = 0; req_data0 = 0;
    rsp_ready0 = 0;

    do_reset();
    for (int a = 0; a < 64; a += 9) do_read(6'(a), 0, 0);

    for (int i = 0; i < 64; i++) do_write(6'(i), 16'(i));
    for (int i = 0; i < 64; i++) do_read(6'(i), 0, 0);

    do_read(6'd5, 10, 1);
    do_read(6'd5, 0, 0);

    do_write(6'd63, 16'hABCD);
    do_write(6'd0, 16'h1357);
    do_read(6'd63, 0, 0);
    do_read(6'd0, 0, 0);
    do_read(6'd62, 0, 0);
    do_read(6'd1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] a;
      a = 6'($urandom_range(63));
      if ($urandom_range(1) == 1) do_write(a, 16'($urandom));
      else do_read(a, int'($urandom_range(3)), 0);
    end

    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 6'd10;
    req_data  = 16'h5555;
    wait_ready();
    tick();
    req_valid = 1'b0;
    check("midwr_w", mem_w, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_w", mem_w, 0);
    check("midrst_e", mem_e, 0);
    check("midrst_rdy", req_ready, 0);
    do_reset();
    do_read(6'd10, 0, 0);
    check("midrst_word", ref_mem[10] == IV, 1);

    tick();
    rst0 = 1'b0;
    #1;
    check("noinit_rdy", req_ready0, 1);
    req_valid0 = 1'b1;
    req_wr0    = 1'b1;
    req_addr0  = 6'd7;
    req_data0  = 16'h1234;
    tick();
    req_valid0 = 1'b0;
    check("noinit_w", mem_w0, 1);
    tick();
    check("noinit_rdy2", req_ready0, 1);
    req_valid0 = 1'b1;
    req_wr0    = 1'b0;
    tick();
    req_valid0 = 1'b0;
    check("noinit_r", mem_r0, 1);
    tick();
    check("noinit_rspv", rsp_valid0, 1);
    check("noinit_data", rsp_data0, 16'h1234);
    rsp_ready0 = 1'b1;
    tick();
    rsp_ready0 = 1'b0;
    check("noinit_idle", req_ready0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
